// File: rtl/wb_write_queue_pkg.sv
// Shared widths, FSM encodings and the queued-write record for the writeback queue.
package wb_write_queue_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;

  // Arbiter FSM encodings, kept as plain constants for legacy tool flows.
  localparam logic [0:0] WBQ_NORMAL = 1'b0;
  localparam logic [0:0] WBQ_DRAIN  = 1'b1;

  typedef logic [REG_FILE_ADDR_LEN-1:0] reg_addr_t;
  typedef logic [WORD_LEN-1:0]          word_t;

  // One pending register-file write.
  typedef struct packed {
    reg_addr_t dest;
    word_t     val;
  } wb_req_t;

  // Decode-stage hazard test: register 0 never carries a dependency.
  function automatic logic src_hit(input reg_addr_t src, input reg_addr_t dst, input logic en);
    return en && (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle between the pipeline/long-latency unit and the writeback queue.
interface wb_write_queue_if;
  import wb_write_queue_pkg::*;

  // In-order pipeline writeback request.
  logic      pipe_wen;
  reg_addr_t pipe_dest;
  word_t     pipe_val;

  // Long-latency unit result handshake.
  logic      mdu_valid;
  reg_addr_t mdu_dest;
  word_t     mdu_val;
  logic      mdu_ready;

  // Registered register-file write port.
  logic      writeEn;
  reg_addr_t dest;
  word_t     writeVal;

  // Decode-stage hazard lookup.
  reg_addr_t src1;
  reg_addr_t src2;
  logic      pend1;
  logic      pend2;

  // Request that the pipeline hold its writeback.
  logic      pipe_stall;

  // The queue itself.
  modport slave (
    input  pipe_wen, pipe_dest, pipe_val,
    input  mdu_valid, mdu_dest, mdu_val,
    output mdu_ready,
    output writeEn, dest, writeVal,
    input  src1, src2,
    output pend1, pend2,
    output pipe_stall
  );

  // The pipeline / long-latency unit side.
  modport master (
    output pipe_wen, pipe_dest, pipe_val,
    output mdu_valid, mdu_dest, mdu_val,
    input  mdu_ready,
    input  writeEn, dest, writeVal,
    output src1, src2,
    input  pend1, pend2,
    input  pipe_stall
  );

endinterface

// File: rtl/wb_write_queue_fifo.sv
// Circular buffer of pending long-latency results with per-entry dest compare.
module wbq_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_req_t   push_req_i,
  input  logic      pop_i,
  output wb_req_t   head_o,
  output logic      empty_o,
  output logic      ready_o,
  input  reg_addr_t src1_i,
  input  reg_addr_t src2_i,
  output logic      hit1_o,
  output logic      hit2_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue refuses pushes and an empty one refuses pops, so the two
  // pointers never address the same slot in one cycle.
  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers, occupancy and the per-slot valid flags.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale slots are masked by vld_q,
    // which keeps the array mappable to plain RAM/flops without reset muxes.
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_req_i;
    end
  end

  // Hazard lookup across every live slot.
  always_comb begin
    hit1_o = 1'b0;
    hit2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (src_hit(src1_i, mem_q[i].dest, vld_q[i])) hit1_o = 1'b1;
      if (src_hit(src2_i, mem_q[i].dest, vld_q[i])) hit2_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write arbiter: in-order pipeline writes win, long-latency
// results wait in a FIFO, and a starvation FSM stalls the pipeline to drain it.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  wb_write_queue_if.slave   bus
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic             pipe_win;
  logic             pop;
  logic             push;
  wb_req_t          push_req;
  wb_req_t          head;
  logic             fifo_empty;
  logic             fifo_ready;
  logic             hit1, hit2;

  logic             wr_en_q, wr_en_d;
  reg_addr_t        wr_dest_q, wr_dest_d;
  word_t            wr_val_q, wr_val_d;

  logic [0:0]       state_q, state_d;
  logic [STV_W-1:0] starve_q, starve_d;

  // Writes to register 0 are accepted but never stored.
  assign push            = bus.mdu_valid && fifo_ready && (bus.mdu_dest != '0);
  assign push_req.dest   = bus.mdu_dest;
  assign push_req.val    = bus.mdu_val;

  wbq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_req_i (push_req),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .ready_o    (fifo_ready),
    .src1_i     (bus.src1),
    .src2_i     (bus.src2),
    .hit1_o     (hit1),
    .hit2_o     (hit2)
  );

  // Arbitration: a real pipeline write wins, otherwise the queue head issues.
  always_comb begin
    pipe_win  = bus.pipe_wen && (bus.pipe_dest != '0);
    pop       = !pipe_win && !fifo_empty;
    wr_en_d   = pipe_win || pop;
    wr_dest_d = '0;
    wr_val_d  = '0;
    if (pipe_win) begin
      wr_dest_d = bus.pipe_dest;
      wr_val_d  = bus.pipe_val;
    end else if (pop) begin
      wr_dest_d = head.dest;
      wr_val_d  = head.val;
    end
  end

  // Starvation tracking: count lost arbitrations, stall until the queue empties.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      WBQ_NORMAL: begin
        if (pop || fifo_empty) begin
          starve_d = '0;
        end else if (pipe_win) begin
          starve_d = starve_q + 1'b1;
        end
        if (starve_d == STV_W'(STARVE_LIMIT)) begin
          state_d = WBQ_DRAIN;
        end
      end
      WBQ_DRAIN: begin
        if (fifo_empty) begin
          state_d  = WBQ_NORMAL;
          starve_d = '0;
        end
      end
      default: begin
        state_d  = WBQ_NORMAL;
        starve_d = '0;
      end
    endcase
  end

  // Registered write port and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_val_q  <= '0;
      state_q   <= WBQ_NORMAL;
      starve_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_val_q  <= wr_val_d;
      state_q   <= state_d;
      starve_q  <= starve_d;
    end
  end

  assign bus.writeEn    = wr_en_q;
  assign bus.dest       = wr_dest_q;
  assign bus.writeVal   = wr_val_q;
  assign bus.mdu_ready  = fifo_ready;
  assign bus.pipe_stall = (state_q == WBQ_DRAIN);

  // A register stays pending while queued or while its write sits on the port.
  assign bus.pend1 = (bus.src1 != '0) && (hit1 || src_hit(bus.src1, wr_dest_q, wr_en_q));
  assign bus.pend2 = (bus.src2 != '0) && (hit2 || src_hit(bus.src2, wr_dest_q, wr_en_q));

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queued long-latency results.
REQ-002 The module SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive lost arbitrations before drain.
REQ-003 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pipe_wen / pipe_dest / pipe_val  input  1 / `REG_FILE_ADDR_LEN / `WORD_LEN  in-order pipeline writeback request.
REQ-006 mdu_valid / mdu_dest / mdu_val  input  1 / `REG_FILE_ADDR_LEN / `WORD_LEN  long-latency unit result.
REQ-007 mdu_ready  output  1  queue can accept an mdu result this cycle.
REQ-008 writeEn / dest / writeVal  output  1 / `REG_FILE_ADDR_LEN / `WORD_LEN  registered write port driving the register file.
REQ-009 src1, src2  input  `REG_FILE_ADDR_LEN  decode-stage source register numbers.
REQ-010 pend1, pend2  output  1  src1 / src2 has a write not yet committed.
REQ-011 pipe_stall  output  1  request that the pipeline hold writeback.

Function
REQ-012 The module SHALL register at most one write per cycle onto writeEn/dest/writeVal; writeEn SHALL be 0 in any cycle with no winner.
REQ-013 Arbitration SHALL be: pipe_wen with pipe_dest != 0 wins; otherwise the queue head is popped and issued if the queue is non-empty.
REQ-014 pipe_wen with pipe_dest == 0 SHALL issue nothing and SHALL let the queue head issue in that cycle.
REQ-015 mdu_ready SHALL equal (count < DEPTH) and SHALL be independent of a same-cycle pop.
REQ-016 A push SHALL occur when mdu_valid && mdu_ready, with entries issued in FIFO order; mdu_dest == 0 SHALL be accepted and discarded.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-018 pendN SHALL be combinational: srcN != 0 and (a valid queue entry has dest == srcN, or writeEn && dest == srcN).
REQ-019 A result pushed in cycle T SHALL affect pend1/pend2 starting in cycle T+1; a same-cycle push SHALL NOT be visible.
REQ-020 FSM states SHALL be NORMAL and DRAIN, and pipe_stall SHALL be 1 exactly in DRAIN (Moore output).
REQ-021 In NORMAL, starve_cnt SHALL increment each cycle the queue is non-empty and the pipeline wins, and SHALL clear on any pop or when the queue is empty.
REQ-022 NORMAL SHALL go to DRAIN on the edge where starve_cnt reaches STARVE_LIMIT.
REQ-023 DRAIN SHALL go to NORMAL on the edge after the queue becomes empty, and starve_cnt SHALL clear on that edge.
REQ-024 In DRAIN, pipe_wen SHALL still win arbitration, and the pipeline keeping pipe_wen low is its own obligation.
REQ-025 While in DRAIN, mdu pushes SHALL still be accepted per REQ-015.

Reset
REQ-026 When rst is sampled high, writeEn, dest, writeVal, count, the pointers and starve_cnt SHALL go to 0, and the state SHALL go to NORMAL.
REQ-027 Queue contents SHALL be discarded on reset, so pend1, pend2, pipe_stall = 0 and mdu_ready = 1 in the first cycle after reset.
REQ-028 A reset in mid-drain or with the queue full SHALL drop all pending entries and issue no write for them.

Structure
REQ-029 WORD_LEN and REG_FILE_ADDR_LEN SHALL come from the shared defines file, which SHALL also hold the FSM state encodings WBQ_NORMAL and WBQ_DRAIN.
REQ-030 The FIFO storage, pointers and per-entry dest compare SHALL be one sub-module, wbq_fifo, and the arbiter/FSM SHALL remain at top level.

Verification
REQ-031 Scenario 1: mdu push (dest=5, val=0x1234) with no pipe activity -> next cycle writeEn=1, dest=5, writeVal=0x1234; pend1 (src1=5) is high for 2 cycles, then low.
REQ-032 Scenario 2: four mdu pushes with no pops -> mdu_ready=0; a fifth mdu_valid is held and not lost; a pop -> mdu_ready=1 next cycle.
REQ-033 Scenario 3: queue holds dest=7 and pipe_wen is held high for 8 cycles -> pipe_stall=1 from cycle 9; pipe_wen low -> dest=7 issues; queue empty -> pipe_stall=0 the next cycle.
REQ-034 Scenario 4: pipe_wen with dest=0 while the queue holds dest=3 -> dest=3 issues in that cycle; an mdu push with dest=0 -> count unchanged and no write.
REQ-035 Scenario 5: rst asserted in DRAIN with 3 entries -> next cycle writeEn=0, pipe_stall=0, mdu_ready=1, and no queued write ever issues.
REQ-036 Scenario 6: simultaneous push and pop at count=2 over 20 random cycles -> count stays 2, and issue order matches push order across pointer wrap.
